// File: rtl/ahb_master_if.sv
// AHB-Lite bus bundle between a word-only master and its slave.
interface ahb_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] haddr;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [2:0]    hburst;
    logic [3:0]    hprot;
    logic [1:0]    htrans;
    logic          hmastlock;
    logic [DW-1:0] hwdata;
    logic          hready;
    logic          hresp;
    logic [DW-1:0] hrdata;

    modport master (
        output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_master.sv
// AHB-Lite word-only master: turns SINGLE/INCR4/WRAP4 commands into pipelined
// address and data phases, honouring wait states and the two-cycle ERROR response.
module ahb_master #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [1:0]    cmd_burst,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    output logic          done,
    output logic          err,
    ahb_master_if.master  bus
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_WRAP4  = 3'b010;
    localparam logic [2:0] HB_INCR4  = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_SEQ,
        S_LAST,
        S_ERR
    } state_t;

    state_t        state;
    logic [1:0]    beat;
    logic [AW-1:0] haddr_q;
    logic          hwrite_q;
    logic [2:0]    hburst_q;
    logic [1:0]    htrans_q;
    logic [DW-1:0] hwdata_q;

    logic          addr_done;
    logic          data_active;
    logic          data_ok;
    logic          data_err;
    logic          last_beat;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] word_addr;
    logic [2:0]    burst_map;

    // SEQ and LAST are exactly the states with a data phase in flight.
    assign addr_done   = (state == S_ADDR || state == S_SEQ) && bus.hready;
    assign data_active = (state == S_SEQ || state == S_LAST);
    assign data_ok     = data_active && bus.hready && !bus.hresp;
    assign data_err    = data_active && !bus.hready && bus.hresp;
    assign last_beat   = (hburst_q == HB_SINGLE) || (beat == 2'd3);
    assign word_addr   = cmd_addr & ~{{(AW-2){1'b0}}, 2'b11};
    assign next_addr   = (hburst_q == HB_WRAP4)
                       ? {haddr_q[AW-1:4], haddr_q[3:2] + 2'd1, 2'b00}
                       : haddr_q + AW'(4);

    assign cmd_ready = (state == S_IDLE);
    assign wr_ack    = addr_done && hwrite_q;

    always_comb begin
        burst_map = HB_SINGLE;
        case (cmd_burst)
            2'b01:   burst_map = HB_INCR4;
            2'b10:   burst_map = HB_WRAP4;
            default: burst_map = HB_SINGLE;
        endcase
    end

    assign bus.haddr     = haddr_q;
    assign bus.hwrite    = hwrite_q;
    assign bus.hsize     = 3'b010;
    assign bus.hburst    = hburst_q;
    assign bus.hprot     = 4'b0011;
    assign bus.htrans    = htrans_q;
    assign bus.hmastlock = 1'b0;
    assign bus.hwdata    = hwdata_q;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= S_IDLE;
            beat     <= 2'd0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hburst_q <= HB_SINGLE;
            htrans_q <= TR_IDLE;
            hwdata_q <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            if (data_ok && !hwrite_q) begin
                rd_data  <= bus.hrdata;
                rd_valid <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        haddr_q  <= word_addr;
                        hwrite_q <= cmd_write;
                        hburst_q <= burst_map;
                        htrans_q <= TR_NONSEQ;
                        beat     <= 2'd0;
                        state    <= S_ADDR;
                    end
                end
                S_ADDR, S_SEQ: begin
                    // First ERROR cycle withdraws the pending SEQ; later beats are dropped.
                    if (data_err) begin
                        htrans_q <= TR_IDLE;
                        state    <= S_ERR;
                    end else if (bus.hready) begin
                        if (hwrite_q) begin
                            hwdata_q <= wr_data;
                        end
                        if (last_beat) begin
                            htrans_q <= TR_IDLE;
                            state    <= S_LAST;
                        end else begin
                            haddr_q  <= next_addr;
                            htrans_q <= TR_SEQ;
                            beat     <= beat + 2'd1;
                            state    <= S_SEQ;
                        end
                    end
                end
                S_LAST: begin
                    if (data_err) begin
                        state <= S_ERR;
                    end else if (bus.hready) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (bus.hready) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
